// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: width functions and the status-flag bundle, reused by
// the synchronous and asynchronous FIFO controllers.
package fifo_pkg;

  // Address width; a depth below 2 still gets a 1-bit pointer.
  function automatic int unsigned fifo_aw(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int unsigned fifo_cw(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

  localparam int unsigned FIFO_DEFAULT_DEPTH = 512;

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Wrapping FIFO pointer: advances on inc_i and returns from Depth-1 to 0,
// so non-power-of-two depths never address past the last entry.
module fifo_wrap_ptr
  import fifo_pkg::*;
#(
  parameter  int unsigned Depth = FIFO_DEFAULT_DEPTH,
  localparam int unsigned AW    = fifo_aw(Depth)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          inc_i,
  output logic [AW-1:0] ptr_o
);

  logic [AW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) begin
      ptr_d = (ptr_q == AW'(Depth - 1)) ? '0 : ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller sequencing a dual-port SRAM with a registered
// read port; tracks occupancy, flags, read-valid and sticky error flags.
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter  int unsigned Depth          = FIFO_DEFAULT_DEPTH,
  parameter  int unsigned AlmostFullThr  = Depth - 4,
  parameter  int unsigned AlmostEmptyThr = 4,
  localparam int unsigned AW             = fifo_aw(Depth),
  localparam int unsigned CW             = fifo_cw(Depth)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_req,
  input  logic          rd_req,
  output logic          sram_wren,
  output logic [AW-1:0] sram_wraddr,
  output logic          sram_rden,
  output logic [AW-1:0] sram_rdaddr,
  output logic          rd_valid,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic          overflow,
  output logic          underflow
);

  logic [CW-1:0] count_q, count_d;
  logic          rd_valid_q, overflow_q, overflow_d, underflow_q, underflow_d;
  logic          wr_acc, rd_acc;
  fifo_flags_t   flags;

  always_comb begin
    flags              = '0;
    flags.full         = (count_q == CW'(Depth));
    flags.empty        = (count_q == '0);
    flags.almost_full  = (32'(count_q) >= AlmostFullThr);
    flags.almost_empty = (32'(count_q) <= AlmostEmptyThr);
  end

  // A pop frees a slot in the same cycle, so a push at full is allowed with it;
  // there is no empty bypass. Nothing is accepted while reset is held.
  assign rd_acc = ~rst & rd_req & ~flags.empty;
  assign wr_acc = ~rst & wr_req & (~flags.full | rd_acc);

  fifo_wrap_ptr #(.Depth(Depth)) u_wr_ptr (
    .clk_i (clk),
    .rst_i (rst),
    .inc_i (wr_acc),
    .ptr_o (sram_wraddr)
  );

  fifo_wrap_ptr #(.Depth(Depth)) u_rd_ptr (
    .clk_i (clk),
    .rst_i (rst),
    .inc_i (rd_acc),
    .ptr_o (sram_rdaddr)
  );

  always_comb begin
    count_d = count_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    overflow_d  = overflow_q  | (wr_req & ~wr_acc);
    underflow_d = underflow_q | (rd_req & ~rd_acc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      rd_valid_q  <= rd_acc;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign sram_wren    = wr_acc;
  assign sram_rden    = rd_acc;
  assign rd_valid     = rd_valid_q;
  assign count        = count_q;
  assign full         = flags.full;
  assign empty        = flags.empty;
  assign almost_full  = flags.almost_full;
  assign almost_empty = flags.almost_empty;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl: Depth=8 (thresholds 6/2) instance for
// fill/drain/corner/reset cases, Depth=5 instance for wrap and data ordering.
module tb_sync_fifo_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Depth=8 instance
  logic       rst = 1'b0, wr = 1'b0, rd = 1'b0;
  logic       wren, rden, rvalid, full, empty, afull, aempty, ovf, udf;
  logic [2:0] wraddr, rdaddr;
  logic [3:0] count;

  sync_fifo_ctrl #(.Depth(8), .AlmostFullThr(6), .AlmostEmptyThr(2)) u_dut8 (
    .clk(clk), .rst(rst), .wr_req(wr), .rd_req(rd),
    .sram_wren(wren), .sram_wraddr(wraddr), .sram_rden(rden), .sram_rdaddr(rdaddr),
    .rd_valid(rvalid), .count(count), .full(full), .empty(empty),
    .almost_full(afull), .almost_empty(aempty), .overflow(ovf), .underflow(udf)
  );

  // Depth=5 instance
  logic       rst5 = 1'b0, wr5 = 1'b0, rd5 = 1'b0;
  logic       wren5, rden5, rvalid5, full5, empty5, afull5, aempty5, ovf5, udf5;
  logic [2:0] wraddr5, rdaddr5, count5;

  sync_fifo_ctrl #(.Depth(5), .AlmostFullThr(4), .AlmostEmptyThr(1)) u_dut5 (
    .clk(clk), .rst(rst5), .wr_req(wr5), .rd_req(rd5),
    .sram_wren(wren5), .sram_wraddr(wraddr5), .sram_rden(rden5), .sram_rdaddr(rdaddr5),
    .rd_valid(rvalid5), .count(count5), .full(full5), .empty(empty5),
    .almost_full(afull5), .almost_empty(aempty5), .overflow(ovf5), .underflow(udf5)
  );

  // Behavioural SRAM with registered read port behind the Depth=5 instance
  logic [7:0] mem [8];
  logic [7:0] wdata5 = '0, rdata5;
  always @(posedge clk) begin
    if (wren5) mem[wraddr5] <= wdata5;
    if (rden5) rdata5 <= mem[rdaddr5];
  end

  int unsigned n_cmp = 0, n_bad = 0;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr = 1'b0; rd = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic push_n(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      wr = 1'b1; rd = 1'b0;
      tick();
    end
    wr = 1'b0;
  endtask

  logic [7:0] sbq [$];
  logic [7:0] pend;
  int unsigned cnt5, ewp, erp;
  logic ew, er, ewacc, eracc;

  initial begin
    // 1. reset with a pending push, then fill
    rst = 1'b1; wr = 1'b1;
    settle();
    check_eq("wren_in_reset", 32'(wren), 0);
    tick();
    rst = 1'b0; wr = 1'b0;
    settle();
    check_eq("rst_count", 32'(count), 0);
    check_eq("rst_empty", 32'(empty), 1);
    check_eq("rst_full", 32'(full), 0);
    check_eq("rst_aempty", 32'(aempty), 1);
    check_eq("rst_afull", 32'(afull), 0);
    check_eq("rst_rvalid", 32'(rvalid), 0);
    check_eq("rst_ovf", 32'(ovf), 0);
    check_eq("rst_udf", 32'(udf), 0);
    for (int unsigned i = 0; i < 8; i++) begin
      wr = 1'b1;
      settle();
      check_eq("push_wren", 32'(wren), 1);
      check_eq("push_wraddr", 32'(wraddr), i);
      tick();
      check_eq("push_count", 32'(count), i + 1);
      check_eq("push_afull", 32'(afull), (i + 1 >= 6) ? 1 : 0);
      check_eq("push_aempty", 32'(aempty), (i + 1 <= 2) ? 1 : 0);
      check_eq("push_full", 32'(full), (i + 1 == 8) ? 1 : 0);
    end
    settle();
    check_eq("push9_wren", 32'(wren), 0);
    tick();
    wr = 1'b0;
    check_eq("push9_ovf", 32'(ovf), 1);
    check_eq("push9_count", 32'(count), 8);

    // 2. drain from full
    for (int unsigned i = 0; i < 8; i++) begin
      rd = 1'b1;
      settle();
      check_eq("pop_rden", 32'(rden), 1);
      check_eq("pop_rdaddr", 32'(rdaddr), i);
      tick();
      check_eq("pop_rvalid", 32'(rvalid), 1);
      check_eq("pop_count", 32'(count), 7 - i);
    end
    settle();
    check_eq("pop9_rden", 32'(rden), 0);
    tick();
    rd = 1'b0;
    check_eq("pop9_udf", 32'(udf), 1);
    check_eq("pop9_empty", 32'(empty), 1);
    check_eq("pop9_rvalid", 32'(rvalid), 0);

    // 3. simultaneous push+pop while full
    do_reset();
    push_n(8);
    wr = 1'b1; rd = 1'b1;
    settle();
    check_eq("fullpp_wren", 32'(wren), 1);
    check_eq("fullpp_rden", 32'(rden), 1);
    tick();
    wr = 1'b0; rd = 1'b0;
    settle();
    check_eq("fullpp_count", 32'(count), 8);
    check_eq("fullpp_wraddr", 32'(wraddr), 1);
    check_eq("fullpp_rdaddr", 32'(rdaddr), 1);
    check_eq("fullpp_ovf", 32'(ovf), 0);
    check_eq("fullpp_rvalid", 32'(rvalid), 1);

    // 4. simultaneous push+pop while empty
    do_reset();
    wr = 1'b1; rd = 1'b1;
    settle();
    check_eq("emptypp_wren", 32'(wren), 1);
    check_eq("emptypp_rden", 32'(rden), 0);
    tick();
    wr = 1'b0; rd = 1'b0;
    check_eq("emptypp_count", 32'(count), 1);
    check_eq("emptypp_udf", 32'(udf), 1);
    check_eq("emptypp_rvalid", 32'(rvalid), 0);

    // 6. reset mid-stream at count=5 with push and pop pending
    do_reset();
    rd = 1'b1;
    tick();
    rd = 1'b0;
    push_n(6);
    rd = 1'b1;
    tick();
    check_eq("pre_rst_count", 32'(count), 5);
    check_eq("pre_rst_udf", 32'(udf), 1);
    wr = 1'b1; rd = 1'b1; rst = 1'b1;
    settle();
    check_eq("midrst_wren", 32'(wren), 0);
    check_eq("midrst_rden", 32'(rden), 0);
    tick();
    rst = 1'b0; wr = 1'b0; rd = 1'b0;
    settle();
    check_eq("midrst_count", 32'(count), 0);
    check_eq("midrst_wraddr", 32'(wraddr), 0);
    check_eq("midrst_rdaddr", 32'(rdaddr), 0);
    check_eq("midrst_empty", 32'(empty), 1);
    check_eq("midrst_rvalid", 32'(rvalid), 0);
    check_eq("midrst_ovf", 32'(ovf), 0);
    check_eq("midrst_udf", 32'(udf), 0);

    // 5. Depth=5 wrap and data ordering
    rst5 = 1'b1;
    tick();
    rst5 = 1'b0;
    cnt5 = 0; ewp = 0; erp = 0;
    for (int unsigned c = 0; c < 20; c++) begin
      ew = (c < 7) ? 1'b1 : (c % 3 != 0);
      er = (c >= 7);
      eracc = er && (cnt5 > 0);
      ewacc = ew && ((cnt5 < 5) || eracc);
      wr5 = ew; rd5 = er; wdata5 = 8'(8'h40 + c);
      settle();
      check_eq("d5_wren", 32'(wren5), 32'(ewacc));
      check_eq("d5_rden", 32'(rden5), 32'(eracc));
      check_eq("d5_wraddr", 32'(wraddr5), ewp);
      check_eq("d5_rdaddr", 32'(rdaddr5), erp);
      check_eq("d5_addr_range", 32'((wraddr5 < 3'd5) && (rdaddr5 < 3'd5)), 1);
      if (eracc) begin
        pend = sbq.pop_front();
        erp = (erp == 4) ? 0 : erp + 1;
        cnt5--;
      end
      if (ewacc) begin
        sbq.push_back(wdata5);
        ewp = (ewp == 4) ? 0 : ewp + 1;
        cnt5++;
      end
      tick();
      check_eq("d5_rvalid", 32'(rvalid5), 32'(eracc));
      if (eracc) check_eq("d5_rdata", 32'(rdata5), 32'(pend));
      check_eq("d5_count", 32'(count5), cnt5);
    end
    wr5 = 1'b0; rd5 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
